remote_req_tx_queue: RTL and testbench
======================================

Name: remote_req_tx_queue

Overview:
- Sits directly downstream of the load/store unit's remote-request output and upstream of the network TX endpoint.
- Buffers outgoing remote requests (icache fetch, remote load/store, AMO) in a small FIFO.
- Gates issue on a network credit counter and reports when every request has drained and been acknowledged, for fence/barrier stalls.

Parameters:
- els_p, 2, FIFO depth in requests (power of two, >=2)
- max_out_credits_p, 32, maximum outstanding network requests
- credit_width_lp (localparam), clog2(max_out_credits_p+1), credit counter width

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- remote_req_i  in  remote_req_s  request from load/store unit
- remote_req_v_i  in  1  request valid
- remote_req_ready_o  out  1  queue can accept this cycle
- tx_req_o  out  remote_req_s  head-of-queue request to network TX
- tx_v_o  out  1  head valid and credit available
- tx_yumi_i  in  1  network TX consumed head this cycle
- credit_return_i  in  1  one response/ack returned (pulse)
- credits_o  out  credit_width_lp  current available credits
- no_outstanding_o  out  1  queue empty and all credits returned

Behaviour:
- Reset (synchronous, active-high): FIFO empty, rd/wr pointers 0, credits = max_out_credits_p. Outputs during/after reset:
  - remote_req_ready_o=1, tx_v_o=0, no_outstanding_o=1, credits_o=max_out_credits_p.
  - Reset mid-operation discards all queued entries and restores full credits.
- Enqueue occurs when remote_req_v_i & remote_req_ready_o.
- remote_req_ready_o = ~full. It does not depend on tx_yumi_i, so there is no same-cycle dequeue-to-enqueue path.
- Latency: no bypass. An enqueued request appears at tx_req_o the next cycle at the earliest.
- tx_v_o = ~empty & (credits != 0). tx_req_o is the head entry. Its contents are stable while tx_v_o=1 and tx_yumi_i=0.
- Dequeue occurs on tx_yumi_i. tx_yumi_i while tx_v_o=0 is illegal (assertion).
- Credit update per cycle:
  - dequeue only: credits-1
  - credit_return_i only: credits+1
  - both in the same cycle: unchanged
- Credit overflow (return at credits==max with no dequeue) is illegal (assertion). The counter saturates at max.
- Credits at 0: head is held and tx_v_o=0. Enqueue continues until the FIFO is full.
- Occupancy counter 0..els_p:
  - simultaneous enqueue and dequeue leaves the count unchanged
  - pointers wrap modulo els_p
- Full: ready=0 and the incoming valid is ignored. Upstream holds the request and the pipeline stalls.
- Empty: tx_v_o=0 regardless of credits.
- no_outstanding_o = empty & (credits == max_out_credits_p), taken from registered state (same-cycle inputs not included).
- Stored data is never modified. The queue is field-agnostic: addr, data, mask, load_info and reg_id all pass through unchanged.

Optional Feature:
- Macro REMOTE_REQ_TX_QUEUE_STATS_EN.
- When defined, adds three 32-bit wrapping counters and outputs:
  - stall_full_cycles_o: cycles with remote_req_v_i & ~ready
  - stall_credit_cycles_o: cycles with ~empty & credits==0
  - issued_o: dequeues
- Counters reset to 0.
- When undefined, these ports and registers do not exist; functionality is otherwise identical.

Decomposition:
- remote_req_s stays in bsg_vanilla_pkg, unchanged.
- Add to the package: localparam remote_req_tx_queue_els_gp = 2 and max_out_credits_gp = 32.
- One sub-module: remote_req_credit_counter (up/down, saturating, simultaneous inc/dec = hold, overflow assertion). It is also reusable by the icache miss path.
- The FIFO storage is a plain register array inside the top module.

Test Plan:
- Reset, then one request (addr 0x8000_0040, store, mask 4'b1111) with tx_yumi_i held 1:
  - tx_v_o rises the next cycle and dequeues
  - credits_o goes 32->31
  - one credit_return_i pulse restores 32 and no_outstanding_o=1
- Three back-to-back requests with tx_yumi_i=0 and els_p=2:
  - ready=0 after two enqueues; the third is held upstream
  - raising yumi drains the entries in order A, B, then C
- Issue 32 requests without any credit return:
  - credits_o=0, tx_v_o=0 with a 33rd request queued
  - a single credit_return_i gives tx_v_o=1 the next cycle
- Credits=5 with simultaneous yumi and credit_return_i: credits stays 5.
- Same cycle, simultaneous enqueue and dequeue with occupancy 1: occupancy stays 1, and the head advances to the newer entry.
- Assert reset with 2 queued and credits=10: the next cycle shows empty, credits=32 and no_outstanding_o=1. With REMOTE_REQ_TX_QUEUE_STATS_EN defined, stall_credit_cycles_o also reads 0 after that reset.

Source files
------------

// File: rtl/bsg_vanilla_pkg.sv
// rtl/bsg_vanilla_pkg.sv - shared vanilla-core request types and queue sizing constants
package bsg_vanilla_pkg;

  localparam int remote_req_tx_queue_els_gp = 2;
  localparam int max_out_credits_gp         = 32;

  typedef struct packed {
    logic       is_unsigned_op;
    logic       is_byte_op;
    logic       is_hex_op;
    logic [1:0] part_sel;
  } load_info_s;

  typedef struct packed {
    logic        write_not_read;
    logic        is_amo_op;
    logic        is_icache_fetch;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data;
    load_info_s  load_info;
    logic [4:0]  reg_id;
  } remote_req_s;

endpackage

// File: rtl/remote_req_tx_queue_credit_counter.sv
// rtl/remote_req_tx_queue_credit_counter.sv - saturating up/down network credit counter
module remote_req_credit_counter
  #(parameter int max_p = 32
   ,localparam int width_lp = $clog2(max_p+1))
  (input  logic                clk_i
  ,input  logic                reset_i
  ,input  logic                inc_i
  ,input  logic                dec_i
  ,output logic [width_lp-1:0] credits_o
  );

  logic [width_lp-1:0] credits_r;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      credits_r <= width_lp'(max_p);
    else if (inc_i && !dec_i && credits_r != width_lp'(max_p))
      credits_r <= credits_r + width_lp'(1);
    else if (dec_i && !inc_i && credits_r != '0)
      credits_r <= credits_r - width_lp'(1);
  end

  // A return with every credit already home means the network acked something never sent.
  always_ff @(posedge clk_i) begin
    if (!reset_i)
      no_overflow: assert (!(inc_i && !dec_i && credits_r == width_lp'(max_p)));
  end

  assign credits_o = credits_r;

endmodule

// File: rtl/remote_req_tx_queue.sv
// rtl/remote_req_tx_queue.sv - credit-gated remote request FIFO; REMOTE_REQ_TX_QUEUE_STATS_EN adds stall/issue counters
module remote_req_tx_queue
  import bsg_vanilla_pkg::*;
  #(parameter int els_p = remote_req_tx_queue_els_gp
   ,parameter int max_out_credits_p = max_out_credits_gp
   ,localparam int credit_width_lp = $clog2(max_out_credits_p+1))
  (input  logic                       clk_i
  ,input  logic                       reset_i
  ,input  remote_req_s                remote_req_i
  ,input  logic                       remote_req_v_i
  ,output logic                       remote_req_ready_o
  ,output remote_req_s                tx_req_o
  ,output logic                       tx_v_o
  ,input  logic                       tx_yumi_i
  ,input  logic                       credit_return_i
  ,output logic [credit_width_lp-1:0] credits_o
  ,output logic                       no_outstanding_o
`ifdef REMOTE_REQ_TX_QUEUE_STATS_EN
  ,output logic [31:0]                stall_full_cycles_o
  ,output logic [31:0]                stall_credit_cycles_o
  ,output logic [31:0]                issued_o
`endif
  );

  localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int count_width_lp = $clog2(els_p+1);

  remote_req_s               mem_r [els_p];
  logic [ptr_width_lp-1:0]   rd_ptr_r, wr_ptr_r;
  logic [count_width_lp-1:0] count_r;
  logic                      empty, full, enq, deq, credits_zero;

  assign empty        = (count_r == '0);
  assign full         = (count_r == count_width_lp'(els_p));
  assign credits_zero = (credits_o == '0);

  assign remote_req_ready_o = ~full;
  assign tx_v_o             = ~empty & ~credits_zero;
  assign tx_req_o           = mem_r[rd_ptr_r];
  assign no_outstanding_o   = empty & (credits_o == credit_width_lp'(max_out_credits_p));

  assign enq = remote_req_v_i & ~full;
  assign deq = tx_yumi_i & tx_v_o;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) wr_ptr_r <= wr_ptr_r + ptr_width_lp'(1);
      if (deq) rd_ptr_r <= rd_ptr_r + ptr_width_lp'(1);
      if (enq && !deq)      count_r <= count_r + count_width_lp'(1);
      else if (deq && !enq) count_r <= count_r - count_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= remote_req_i;
  end

  remote_req_credit_counter #(.max_p(max_out_credits_p)) credit_counter
    (.clk_i    (clk_i)
    ,.reset_i  (reset_i)
    ,.inc_i    (credit_return_i)
    ,.dec_i    (deq)
    ,.credits_o(credits_o)
    );

  always_ff @(posedge clk_i) begin
    if (!reset_i)
      yumi_legal: assert (!(tx_yumi_i && !tx_v_o));
  end

`ifdef REMOTE_REQ_TX_QUEUE_STATS_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_full_cycles_o   <= '0;
      stall_credit_cycles_o <= '0;
      issued_o              <= '0;
    end else begin
      if (remote_req_v_i && full)  stall_full_cycles_o   <= stall_full_cycles_o + 32'd1;
      if (!empty && credits_zero)  stall_credit_cycles_o <= stall_credit_cycles_o + 32'd1;
      if (deq)                     issued_o              <= issued_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_remote_req_tx_queue.sv
// tb/tb_remote_req_tx_queue.sv - randomized and directed bench against a queue-based reference model
module tb_remote_req_tx_queue;
  import bsg_vanilla_pkg::*;

  localparam int ELS = remote_req_tx_queue_els_gp;
  localparam int MAX = max_out_credits_gp;

  logic        clk = 0;
  logic        reset = 1;
  remote_req_s req_in = '0;
  logic        v_in = 0, yumi = 0, cret = 0;
  logic        ready, tx_v, no_out;
  remote_req_s tx_req;
  logic [5:0]  credits;
`ifdef REMOTE_REQ_TX_QUEUE_STATS_EN
  logic [31:0] st_full, st_cred, st_iss;
`endif

  always #5 clk = ~clk;

  remote_req_tx_queue dut
    (.clk_i(clk), .reset_i(reset)
    ,.remote_req_i(req_in), .remote_req_v_i(v_in), .remote_req_ready_o(ready)
    ,.tx_req_o(tx_req), .tx_v_o(tx_v), .tx_yumi_i(yumi)
    ,.credit_return_i(cret), .credits_o(credits), .no_outstanding_o(no_out)
`ifdef REMOTE_REQ_TX_QUEUE_STATS_EN
    ,.stall_full_cycles_o(st_full), .stall_credit_cycles_o(st_cred), .issued_o(st_iss)
`endif
    );

  int compared = 0, mismatched = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of requests plus an integer credit pool.
  remote_req_s mq[$];
  int          m_cred = MAX;
  bit          started = 0;
  bit          m_enq, m_deq;
  logic [31:0] m_sfull = 0, m_scred = 0, m_iss = 0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_cred = MAX;
      m_sfull = 0; m_scred = 0; m_iss = 0;
      started = 1;
    end else if (started) begin
      m_enq = v_in && (mq.size() < ELS);
      m_deq = yumi && (mq.size() > 0) && (m_cred > 0);
      if (v_in && mq.size() == ELS) m_sfull++;
      if (mq.size() > 0 && m_cred == 0) m_scred++;
      if (m_deq) begin void'(mq.pop_front()); m_iss++; end
      if (m_enq) mq.push_back(req_in);
      if (m_deq && !cret) m_cred--;
      else if (cret && !m_deq && m_cred < MAX) m_cred++;
    end
  end

  function automatic bit m_v();
    return (mq.size() > 0) && (m_cred > 0);
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("ready", ready, mq.size() < ELS);
      chk("tx_v", tx_v, m_v());
      chk("credits", credits, m_cred);
      chk("no_outstanding", no_out, (mq.size() == 0) && (m_cred == MAX));
      if (m_v()) chk("tx_req", tx_req, mq[0]);
`ifdef REMOTE_REQ_TX_QUEUE_STATS_EN
      chk("stall_full", st_full, m_sfull);
      chk("stall_credit", st_cred, m_scred);
      chk("issued", st_iss, m_iss);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic remote_req_s mk(input logic [31:0] addr, input logic wr, input logic [3:0] mask);
    remote_req_s r;
    r = '0;
    r.addr = addr; r.write_not_read = wr; r.mask = mask;
    r.data = addr ^ 32'h5a5a_0000; r.reg_id = addr[6:2];
    return r;
  endfunction

  function automatic remote_req_s rnd_req();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[$bits(remote_req_s)-1:0];
  endfunction

  logic [31:0] rec[$];
  bit          c_in;

  initial begin
    step(); step();
    reset = 0;
    chk("rst_ready", ready, 1'b1);
    chk("rst_tx_v", tx_v, 1'b0);
    chk("rst_credits", credits, 6'd32);
    chk("rst_no_out", no_out, 1'b1);

    // Single store request
    v_in = 1; req_in = mk(32'h8000_0040, 1'b1, 4'b1111);
    step();
    v_in = 0;
    chk("t1_tx_v", tx_v, 1'b1);
    chk("t1_addr", tx_req.addr, 32'h8000_0040);
    chk("t1_mask", tx_req.mask, 4'b1111);
    yumi = 1;
    step();
    yumi = 0;
    chk("t1_credits31", credits, 6'd31);
    chk("t1_no_out0", no_out, 1'b0);
    cret = 1;
    step();
    cret = 0;
    chk("t1_credits32", credits, 6'd32);
    chk("t1_no_out1", no_out, 1'b1);

    // Back-to-back A, B, C with no yumi
    v_in = 1; req_in = mk(32'h0000_1000, 1'b0, 4'b0001);
    step();
    req_in = mk(32'h0000_2000, 1'b0, 4'b0010);
    step();
    chk("t2_full_ready", ready, 1'b0);
    req_in = mk(32'h0000_3000, 1'b1, 4'b0100);
    step();
    chk("t2_held_ready", ready, 1'b0);
    c_in = 0;
    for (int i = 0; i < 12 && !(c_in && mq.size() == 0); i++) begin
      yumi = m_v();
      if (yumi) rec.push_back(tx_req.addr);
      if (v_in && mq.size() < ELS) c_in = 1;
      step();
      v_in = !c_in;
    end
    yumi = 0; v_in = 0;
    chk("t2_count", rec.size(), 3);
    if (rec.size() == 3) begin
      chk("t2_order_a", rec[0], 32'h0000_1000);
      chk("t2_order_b", rec[1], 32'h0000_2000);
      chk("t2_order_c", rec[2], 32'h0000_3000);
    end

    // Restore the three credits, then issue 32 with no returns
    cret = 1;
    for (int i = 0; i < 3; i++) step();
    cret = 0;
    chk("t3_start_credits", credits, 6'd32);
    for (int i = 0; i < 200 && m_cred > 0; i++) begin
      v_in = 1; req_in = rnd_req();
      yumi = m_v();
      step();
    end
    yumi = 0;
    step(); step();
    v_in = 0;
    chk("t3_credits0", credits, 6'd0);
    chk("t3_tx_v0", tx_v, 1'b0);
    chk("t3_full", ready, 1'b0);
`ifdef REMOTE_REQ_TX_QUEUE_STATS_EN
    chk("t3_issued", st_iss, 32'd36);
`endif
    cret = 1;
    step();
    chk("t3_tx_v1", tx_v, 1'b1);
    chk("t3_credits1", credits, 6'd1);
    for (int i = 0; i < 4; i++) step();
    cret = 0;
    chk("t4_credits5", credits, 6'd5);

    // Simultaneous yumi and return hold credits
    yumi = 1; cret = 1;
    step();
    yumi = 0; cret = 0;
    chk("t4_hold5", credits, 6'd5);

    // Simultaneous enqueue and dequeue at occupancy 1
    v_in = 1; yumi = 1; req_in = mk(32'h0000_d000, 1'b0, 4'b1000);
    step();
    v_in = 0; yumi = 0;
    chk("t5_ready", ready, 1'b1);
    chk("t5_tx_v", tx_v, 1'b1);
    chk("t5_head", tx_req.addr, 32'h0000_d000);
    chk("t5_credits4", credits, 6'd4);

    // Reset with two queued and credits at 10
    v_in = 1; req_in = mk(32'h0000_e000, 1'b1, 4'b1111);
    step();
    v_in = 0; cret = 1;
    for (int i = 0; i < 6; i++) step();
    cret = 0;
    chk("t6_credits10", credits, 6'd10);
    chk("t6_full", ready, 1'b0);
    reset = 1;
    step();
    chk("t6_tx_v", tx_v, 1'b0);
    chk("t6_ready", ready, 1'b1);
    chk("t6_credits32", credits, 6'd32);
    chk("t6_no_out", no_out, 1'b1);
`ifdef REMOTE_REQ_TX_QUEUE_STATS_EN
    chk("t6_stall_credit", st_cred, 32'd0);
`endif
    reset = 0;

    // Randomized traffic, occasional reset
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 599) == 0);
      v_in   = ($urandom_range(0, 99) < 60);
      req_in = rnd_req();
      yumi   = m_v() && ($urandom_range(0, 99) < 65);
      cret   = (m_cred < MAX || yumi) && ($urandom_range(0, 99) < 30);
      step();
    end
    reset = 0; v_in = 0; yumi = 0; cret = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
